// File: rtl/sw_button_ctrl_if.sv
// Pushbutton inputs and stopwatch control outputs of sw_button_ctrl.
// master drives the raw buttons; slave is the control stage itself.
interface sw_button_ctrl_if;
    logic       btn_startstop;
    logic       btn_lap;
    logic       btn_clear;
    logic       run;
    logic       clr;
    logic       hold;
    logic [1:0] state;

    modport master (
        output btn_startstop, btn_lap, btn_clear,
        input  run, clr, hold, state
    );

    modport slave (
        input  btn_startstop, btn_lap, btn_clear,
        output run, clr, hold, state
    );
endinterface

// File: rtl/sw_button_ctrl.sv
// Stopwatch button front end: sync, debounce, press events and control FSM.
// Optional macro LONG_PRESS_CLEAR_EN adds a long-press clear from any state.
module sw_button_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int LONG_PRESS_CYCLES = 200_000_000
) (
    input  logic              clk,
    input  logic              reset_st,
    sw_button_ctrl_if.slave   bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_param_check
        $error("sw_button_ctrl: cycle parameters must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10,
        ST_LAP     = 2'b11
    } state_t;

    // Bit order for all per-button vectors: 0 startstop, 1 lap, 2 clear
    logic [2:0] btn_raw;
    logic [2:0] btn_ev;

    assign btn_raw = {bus.btn_clear, bus.btn_lap, bus.btn_startstop};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic            sync0_reg;
        logic            sync1_reg;
        logic            db_reg;
        logic            db_q_reg;
        logic            ev_reg;
        logic [DB_W-1:0] cnt_reg;

        // Counter only advances while the synchronised level disagrees
        // with the accepted one, so any shorter glitch is forgotten.
        always_ff @(posedge clk or posedge reset_st) begin
            if (reset_st) begin
                sync0_reg <= 1'b0;
                sync1_reg <= 1'b0;
                db_reg    <= 1'b0;
                db_q_reg  <= 1'b0;
                ev_reg    <= 1'b0;
                cnt_reg   <= '0;
            end else begin
                sync0_reg <= btn_raw[gi];
                sync1_reg <= sync0_reg;
                db_q_reg  <= db_reg;
                ev_reg    <= db_reg & ~db_q_reg;
                if (sync1_reg != db_reg) begin
                    if (cnt_reg == DB_LAST) begin
                        db_reg  <= sync1_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end
        end

        assign btn_ev[gi] = ev_reg;
    end

`ifdef LONG_PRESS_CLEAR_EN
    localparam int LP_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [LP_W-1:0] lp_cnt_reg;
    logic            lp_fired_reg;
    logic            clear_level;
    logic            lp_fire;

    assign clear_level = g_btn[2].db_reg;
    assign lp_fire     = clear_level & ~lp_fired_reg & (lp_cnt_reg == LP_LAST);

    // Fires once per hold; re-arms only when the debounced clear drops
    always_ff @(posedge clk or posedge reset_st) begin
        if (reset_st) begin
            lp_cnt_reg   <= '0;
            lp_fired_reg <= 1'b0;
        end else if (!clear_level) begin
            lp_cnt_reg   <= '0;
            lp_fired_reg <= 1'b0;
        end else if (!lp_fired_reg) begin
            if (lp_fire) begin
                lp_fired_reg <= 1'b1;
                lp_cnt_reg   <= '0;
            end else begin
                lp_cnt_reg   <= lp_cnt_reg + 1'b1;
            end
        end
    end
`else
    logic lp_fire;
    assign lp_fire = 1'b0;
`endif

    state_t state_reg;
    state_t state_next;
    logic   clr_next;
    logic   run_reg;
    logic   hold_reg;
    logic   clr_reg;

    // Event priority: startstop, then lap, then clear; lower ones dropped
    always_comb begin
        state_next = state_reg;
        clr_next   = 1'b0;
        if (btn_ev[0]) begin
            case (state_reg)
                ST_IDLE:    state_next = ST_RUNNING;
                ST_RUNNING: state_next = ST_PAUSED;
                ST_LAP:     state_next = ST_PAUSED;
                ST_PAUSED:  state_next = ST_RUNNING;
                default:    state_next = ST_IDLE;
            endcase
        end else if (btn_ev[1]) begin
            case (state_reg)
                ST_RUNNING: state_next = ST_LAP;
                ST_LAP:     state_next = ST_RUNNING;
                default:    state_next = state_reg;
            endcase
        end else if (btn_ev[2]) begin
            case (state_reg)
                ST_IDLE: begin
                    clr_next = 1'b1;
                end
                ST_PAUSED: begin
                    state_next = ST_IDLE;
                    clr_next   = 1'b1;
                end
                default: state_next = state_reg;
            endcase
        end
        if (lp_fire) begin
            state_next = ST_IDLE;
            clr_next   = 1'b1;
        end
    end

    // Outputs decoded from the next state so they move with state
    always_ff @(posedge clk or posedge reset_st) begin
        if (reset_st) begin
            state_reg <= ST_IDLE;
            run_reg   <= 1'b0;
            hold_reg  <= 1'b0;
            clr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            run_reg   <= (state_next == ST_RUNNING) || (state_next == ST_LAP);
            hold_reg  <= (state_next == ST_LAP);
            clr_reg   <= clr_next;
        end
    end

    assign bus.state = state_reg;
    assign bus.run   = run_reg;
    assign bus.hold  = hold_reg;
    assign bus.clr   = clr_reg;

endmodule

// File: tb/tb_sw_button_ctrl.sv
// Self-checking bench for sw_button_ctrl: vector table, corner sequences and
// randomized buttons compared every cycle against a history-based model.
module tb_sw_button_ctrl;

    localparam int D  = 4;
    localparam int LP = 20;

    logic clk = 1'b0;
    logic reset_st;

    sw_button_ctrl_if bus ();

    sw_button_ctrl #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (LP)
    ) dut (
        .clk      (clk),
        .reset_st (reset_st),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int clr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Raw samples are kept per clock edge. A button's accepted level flips at
    // edge e when the raw samples of edges e-D-1 .. e-2 all disagree with it;
    // the FSM reacts at edge e to a rise accepted at edge e-2.
    bit raw_h  [3][64];
    bit rise_h [3][64];
    bit db_m   [3];
    int cyc  = 0;
    int base = 0;
    int st_m;
    bit run_m, hold_m, clr_m;
`ifdef LONG_PRESS_CLEAR_EN
    int lp_len;
    bit lp_fired;
`endif

    always @(posedge clk or posedge reset_st) begin
        if (reset_st) begin
            base <= cyc + 1;
            for (int b = 0; b < 3; b++) db_m[b] <= 1'b0;
            st_m   <= 0;
            run_m  <= 1'b0;
            hold_m <= 1'b0;
            clr_m  <= 1'b0;
`ifdef LONG_PRESS_CLEAR_EN
            lp_len   <= 0;
            lp_fired <= 1'b0;
`endif
        end else begin : mdl
            int e;
            int ns;
            bit nclr;
            bit fire;
            bit flip;
            bit raw_b;
            bit ev_m [3];
            e = cyc + 1;
            for (int b = 0; b < 3; b++) begin
                raw_b = (b == 0) ? bus.btn_startstop : (b == 1) ? bus.btn_lap : bus.btn_clear;
                ev_m[b] = (e - 2 >= base) ? rise_h[b][(e - 2) & 63] : 1'b0;
                flip = 1'b1;
                for (int i = e - D - 1; i <= e - 2; i++)
                    if (((i >= base) ? raw_h[b][i & 63] : 1'b0) == db_m[b]) flip = 1'b0;
                raw_h[b][e & 63]  <= raw_b;
                rise_h[b][e & 63] <= flip & ~db_m[b];
                if (flip) db_m[b] <= ~db_m[b];
            end
            fire = 1'b0;
`ifdef LONG_PRESS_CLEAR_EN
            if (db_m[2]) begin
                lp_len <= lp_len + 1;
                if (lp_len + 1 == LP && !lp_fired) begin
                    fire = 1'b1;
                    lp_fired <= 1'b1;
                end
            end else begin
                lp_len   <= 0;
                lp_fired <= 1'b0;
            end
`endif
            // States: 0 idle, 1 running, 2 paused, 3 lap
            ns   = st_m;
            nclr = 1'b0;
            if (ev_m[0]) ns = (st_m == 0 || st_m == 2) ? 1 : 2;
            else if (ev_m[1]) begin
                if (st_m == 1) ns = 3;
                else if (st_m == 3) ns = 1;
            end else if (ev_m[2]) begin
                if (st_m == 0) nclr = 1'b1;
                else if (st_m == 2) begin
                    ns = 0;
                    nclr = 1'b1;
                end
            end
            if (fire) begin
                ns = 0;
                nclr = 1'b1;
            end
            st_m   <= ns;
            clr_m  <= nclr;
            run_m  <= (ns == 1 || ns == 3);
            hold_m <= (ns == 3);
            cyc    <= e;
        end
    end

    // Cycle-by-cycle comparison on the falling edge
    always @(negedge clk) begin
        check("model_state", 32'(bus.state), st_m);
        check("model_run",   32'(bus.run),   32'(run_m));
        check("model_hold",  32'(bus.hold),  32'(hold_m));
        check("model_clr",   32'(bus.clr),   32'(clr_m));
        check("inv_run_and_clr",  32'(bus.run & bus.clr),   0);
        check("inv_hold_no_run",  32'(bus.hold & ~bus.run), 0);
        if (bus.clr === 1'b1) clr_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit [2:0] m);
        bus.btn_startstop = m[0];
        bus.btn_lap       = m[1];
        bus.btn_clear     = m[2];
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset_st = 1'b1;
        cycles(2);
        reset_st = 1'b0;
    endtask

    typedef struct {
        bit [2:0] press;
        int       st;
        bit       run;
        bit       hold;
        int       clrs;
    } vec_t;

    vec_t tbl [15];

    task automatic apply_press(input bit [2:0] m);
        drive(m);
        cycles(8);
        drive(3'b000);
        cycles(12);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // press mask bits: 0 startstop, 1 lap, 2 clear
        tbl[0]  = '{3'b001, 1, 1'b1, 1'b0, 0};
        tbl[1]  = '{3'b010, 3, 1'b1, 1'b1, 0};
        tbl[2]  = '{3'b010, 1, 1'b1, 1'b0, 0};
        tbl[3]  = '{3'b001, 2, 1'b0, 1'b0, 0};
        tbl[4]  = '{3'b100, 0, 1'b0, 1'b0, 1};
        tbl[5]  = '{3'b100, 0, 1'b0, 1'b0, 1};
        tbl[6]  = '{3'b010, 0, 1'b0, 1'b0, 0};
        tbl[7]  = '{3'b001, 1, 1'b1, 1'b0, 0};
        tbl[8]  = '{3'b100, 1, 1'b1, 1'b0, 0};
        tbl[9]  = '{3'b111, 2, 1'b0, 1'b0, 0};
        tbl[10] = '{3'b010, 2, 1'b0, 1'b0, 0};
        tbl[11] = '{3'b001, 1, 1'b1, 1'b0, 0};
        tbl[12] = '{3'b010, 3, 1'b1, 1'b1, 0};
        tbl[13] = '{3'b001, 2, 1'b0, 1'b0, 0};
        tbl[14] = '{3'b100, 0, 1'b0, 1'b0, 1};

        drive(3'b000);
        reset_st = 1'b1;
        cycles(3);
        reset_st = 1'b0;
        check("reset_state", 32'(bus.state), 0);
        check("reset_run",   32'(bus.run),   0);
        check("reset_hold",  32'(bus.hold),  0);
        check("reset_clr",   32'(bus.clr),   0);

        // Short glitch must be rejected
        clr_cnt = 0;
        drive(3'b001);
        cycles(D - 1);
        drive(3'b000);
        cycles(12);
        check("glitch_state", 32'(bus.state), 0);
        check("glitch_run",   32'(bus.run),   0);

        // Raw rise to run: 2 sync + D debounce + 1 event + 1 state
        drive(3'b001);
        for (int k = 1; k <= 2 + D + 2; k++) begin
            cycles(1);
            if (k == 2 + D + 1) check("latency_run_early", 32'(bus.run), 0);
            if (k == 2 + D + 2) begin
                check("latency_run",   32'(bus.run),   1);
                check("latency_state", 32'(bus.state), 1);
            end
        end
        drive(3'b000);
        cycles(12);

        // Asynchronous reset while running, with a button held through it
        @(posedge clk);
        #1 reset_st = 1'b1;
        #1;
        check("async_reset_state", 32'(bus.state), 0);
        check("async_reset_run",   32'(bus.run),   0);
        check("async_reset_hold",  32'(bus.hold),  0);
        check("async_reset_clr",   32'(bus.clr),   0);
        drive(3'b001);
        cycles(2);
        reset_st = 1'b0;
        cycles(12);
        check("held_through_reset_state", 32'(bus.state), 1);
        drive(3'b000);
        cycles(12);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            clr_cnt = 0;
            apply_press(tbl[i].press);
            check($sformatf("tbl%0d_state", i), 32'(bus.state), tbl[i].st);
            check($sformatf("tbl%0d_run", i),   32'(bus.run),   32'(tbl[i].run));
            check($sformatf("tbl%0d_hold", i),  32'(bus.hold),  32'(tbl[i].hold));
            check($sformatf("tbl%0d_clrs", i),  clr_cnt,        tbl[i].clrs);
            $display("step %0d press=%b state=%0d run=%0d hold=%0d clr_pulses=%0d",
                     i, tbl[i].press, bus.state, bus.run, bus.hold, clr_cnt);
        end

`ifdef LONG_PRESS_CLEAR_EN
        apply_press(3'b001);
        check("lp_pre_state", 32'(bus.state), 1);
        clr_cnt = 0;
        drive(3'b100);
        cycles(3 * LP);
        check("lp_clr_pulses", clr_cnt, 1);
        check("lp_state", 32'(bus.state), 0);
        check("lp_run",   32'(bus.run),   0);
        drive(3'b000);
        cycles(12);
`endif

        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 99) < 2) do_reset();
            drive(3'($urandom_range(0, 7)));
            cycles($urandom_range(1, 10));
        end
        drive(3'b000);
        cycles(12);
        $display("random phase done at cycle %0d", cyc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
